// File: rtl/ext_sram_responder.sv
// SRAM-side memory-block responder: claims word accesses in its address window and
// runs them as one or two 16-bit phases on an asynchronous external SRAM.
module ext_sram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned ADDR_BITS   = 20,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 wen,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    input  logic [3:0]           byte_en,
    output logic [31:0]          sram_rdata,
    output logic                 sram_wait,
    output logic                 sram_active,
    output logic [ADDR_BITS-2:0] sram_a,
    output logic [15:0]          sram_dq_out,
    input  logic [15:0]          sram_dq_in,
    output logic                 sram_dq_oe,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic                 sram_lb_n,
    output logic                 sram_ub_n
);

    localparam int unsigned     PCW     = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [PCW-1:0]  PC_LAST = PCW'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_DONE} state_t;

    state_t                 state_q, state_d;
    logic [PCW-1:0]         pc_q, pc_d;
    logic                   wen_q, wen_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             be_q, be_d;
    logic [ADDR_BITS-3:0]   wa_q, wa_d;

    logic [31:0]            rdata_q;
    logic [ADDR_BITS-2:0]   a_q;
    logic [15:0]            dq_out_q;
    logic                   dq_oe_q, ce_n_q, oe_n_q, we_n_q, lb_n_q, ub_n_q;

    logic                   hit;
    logic                   phase_d, hi_d, wr_phase_d;
    logic [1:0]             be_half_d;
    logic                   cap_lo, cap_hi;
    logic                   unused_addr_lsbs;

    assign hit              = (addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
    assign unused_addr_lsbs = ^addr[1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        wa_d    = wa_q;
        case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (hit) begin
                    wen_d   = wen;
                    wdata_d = wdata;
                    be_d    = byte_en;
                    wa_d    = addr[ADDR_BITS-1:2];
                    if (!wen || byte_en[1:0] != '0)
                        state_d = ST_LO;
                    else if (byte_en[3:2] != '0)
                        state_d = ST_HI;
                    else
                        state_d = ST_DONE;
                end
            end
            ST_LO, ST_HI: begin
                if (!hit) begin
                    state_d = ST_IDLE;
                    pc_d    = '0;
                end else if (pc_q == PC_LAST) begin
                    pc_d = '0;
                    if (state_q == ST_HI || (wen_q && be_q[3:2] == '0))
                        state_d = ST_DONE;
                    else
                        state_d = ST_HI;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so each one is valid for the
    // whole cycle the FSM spends in the corresponding phase.
    assign phase_d    = (state_d == ST_LO) || (state_d == ST_HI);
    assign hi_d       = (state_d == ST_HI);
    assign wr_phase_d = phase_d && wen_d;
    assign be_half_d  = hi_d ? be_d[3:2] : be_d[1:0];

    assign cap_lo = (state_q == ST_LO) && hit && !wen_q && (pc_q == PC_LAST);
    assign cap_hi = (state_q == ST_HI) && hit && !wen_q && (pc_q == PC_LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            wa_q     <= '0;
            rdata_q  <= '0;
            a_q      <= '0;
            dq_out_q <= '0;
            dq_oe_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            wa_q     <= wa_d;
            ce_n_q   <= !phase_d;
            oe_n_q   <= !(phase_d && !wen_d);
            we_n_q   <= !(wr_phase_d && (pc_d < PC_LAST));
            lb_n_q   <= wr_phase_d ? !be_half_d[0] : !phase_d;
            ub_n_q   <= wr_phase_d ? !be_half_d[1] : !phase_d;
            dq_oe_q  <= wr_phase_d;
            dq_out_q <= wr_phase_d ? (hi_d ? wdata_d[31:16] : wdata_d[15:0]) : '0;
            if (phase_d)
                a_q <= {wa_d, hi_d};
            if (cap_lo)
                rdata_q[15:0] <= sram_dq_in;
            if (cap_hi)
                rdata_q[31:16] <= sram_dq_in;
        end
    end

    assign sram_active = hit;
    assign sram_wait   = hit && (state_q != ST_DONE);
    assign sram_rdata  = rdata_q;
    assign sram_a      = a_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_lb_n   = lb_n_q;
    assign sram_ub_n   = ub_n_q;

endmodule

// File: tb/tb_ext_sram_responder.sv
// Bench for ext_sram_responder: behavioural SRAM device, word-level reference memory,
// and a scoreboard popped by a monitor whenever an access completes.
module tb_ext_sram_responder;

    localparam int unsigned W    = 2;
    localparam int unsigned AB   = 20;
    localparam logic [31:0] MISS = 32'h4000_0000;

    logic          CLK, nRST, wen;
    logic [31:0]   addr, wdata, sram_rdata;
    logic [3:0]    byte_en;
    logic          sram_wait, sram_active, sram_dq_oe;
    logic [AB-2:0] sram_a;
    logic [15:0]   sram_dq_out, sram_dq_in;
    logic          sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    ext_sram_responder #(
        .BASE_ADDR  (32'h8000_0000),
        .ADDR_BITS  (AB),
        .WAIT_CYCLES(W)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .wen        (wen),
        .addr       (addr),
        .wdata      (wdata),
        .byte_en    (byte_en),
        .sram_rdata (sram_rdata),
        .sram_wait  (sram_wait),
        .sram_active(sram_active),
        .sram_a     (sram_a),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_lb_n  (sram_lb_n),
        .sram_ub_n  (sram_ub_n)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // External SRAM device: 256 halfwords, aliased on sram_a[7:0].
    logic [15:0] dev [256];
    logic [15:0] img [256];
    logic        dev_load;

    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? dev[sram_a[7:0]] : 16'h0000;

    always @(posedge CLK) begin
        if (dev_load) begin
            for (int i = 0; i < 256; i++) dev[i] <= img[i];
        end else if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) dev[sram_a[7:0]][7:0]  <= sram_dq_out[7:0];
            if (!sram_ub_n) dev[sram_a[7:0]][15:8] <= sram_dq_out[15:8];
        end
    end

    typedef struct {
        bit          wr;
        logic [31:0] exp_rd;
        logic [31:0] exp_mem;
        logic [6:0]  word;
        int unsigned lat;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] ref_mem [128];
    logic [31:0] model_rdata;
    int          total, bad;

    // state shared between the stimulus and monitor branches of the one initial block
    bit          cur_wen;
    logic [31:0] cur_a, cur_d;
    logic [3:0]  cur_be;
    int unsigned cyc, ph, acc_ce;
    bit          prev_ce_low, prev_a0;
    logic [AB-2:0] last_a;

    function automatic int unsigned exp_lat(bit w, logic [3:0] be);
        if (!w || (be[1:0] != 2'b00 && be[3:2] != 2'b00)) return 2 * W + 3;
        if (be == 4'b0000) return 1;
        return W + 2;
    endfunction

    function automatic int unsigned exp_ce(bit w, logic [3:0] be);
        int unsigned phases;
        if (!w) phases = 2;
        else phases = ((be[1:0] != 2'b00) ? 1 : 0) + ((be[3:2] != 2'b00) ? 1 : 0);
        return phases * (W + 1);
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_access(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_t e;
        int   n;
        e.word = a[8:2];
        if (!w) begin
            model_rdata = ref_mem[e.word];
        end else begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[e.word][8*b +: 8] = d[8*b +: 8];
        end
        e.wr      = w;
        e.exp_rd  = model_rdata;
        e.exp_mem = ref_mem[e.word];
        e.lat     = exp_lat(w, be);
        sbq.push_back(e);
        @(posedge CLK);
        #1;
        cur_wen = w; cur_a = a; cur_d = d; cur_be = be; acc_ce = 0;
        wen = w; addr = a; wdata = d; byte_en = be;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (sram_wait && n < 100);
        if (sram_wait) chk(1'b0, "access_timeout", 32'(n), 32'(e.lat));
        chk(acc_ce == exp_ce(w, be), "ce_cycles", 32'(acc_ce), 32'(exp_ce(w, be)));
        @(posedge CLK);
        #1;
        wen = 1'b0; addr = MISS; byte_en = 4'b0000;
    endtask

    initial begin
        logic [31:0] rw;
        nRST = 1'b0; wen = 1'b0; addr = 32'h8000_0010; wdata = '0; byte_en = '0;
        cur_wen = 1'b0; cur_a = 32'h8000_0010; cur_d = '0; cur_be = '0;
        cyc = 0; ph = 0; acc_ce = 0; prev_ce_low = 1'b0; prev_a0 = 1'b0; last_a = '0;
        total = 0; bad = 0; model_rdata = '0;
        for (int i = 0; i < 128; i++) begin
            rw = $urandom;
            ref_mem[i] = rw;
            img[2*i]   = rw[15:0];
            img[2*i+1] = rw[31:16];
        end
        ref_mem[4] = 32'hDEAD_BEEF; img[8] = 16'hBEEF; img[9] = 16'hDEAD;
        dev_load = 1'b1;

        fork
            begin : stim
                @(posedge CLK);
                #1 dev_load = 1'b0;
                @(negedge CLK);
                chk({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n} == 5'b11111,
                    "rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'h1f);
                chk(sram_dq_oe == 1'b0, "rst_dq_oe", 32'(sram_dq_oe), 32'h0);
                chk(sram_rdata == 32'h0, "rst_rdata", sram_rdata, 32'h0);
                chk(sram_wait == 1'b1, "rst_wait", 32'(sram_wait), 32'h1);
                addr = MISS;
                @(posedge CLK);
                #1 nRST = 1'b1;

                do_access(1'b0, 32'h8000_0010, 32'h0, 4'b0000);
                do_access(1'b1, 32'h8000_0020, 32'h1122_3344, 4'b0110);
                chk(({dev[8'h11], dev[8'h10]} & 32'h00FF_FF00) == 32'h0022_3300,
                    "partial_write", {dev[8'h11], dev[8'h10]}, 32'h0022_3300);
                do_access(1'b1, 32'h8000_0020, 32'hA5A5_5A5A, 4'b1100);
                chk(last_a == 19'h11, "hi_only_addr", 32'(last_a), 32'h11);
                do_access(1'b1, 32'h8000_0024, 32'hCAFE_F00D, 4'b0000);
                do_access(1'b1, 32'h8000_0028, 32'h0BAD_F00D, 4'b0011);
                do_access(1'b0, 32'h8000_0020, 32'h0, 4'b1111);

                @(posedge CLK);
                #1 addr = MISS; wen = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge CLK);
                    chk(!sram_active && !sram_wait && sram_ce_n, "miss",
                        32'({sram_active, sram_wait, sram_ce_n}), 32'h1);
                end

                // abort a read early in its LO phase
                @(posedge CLK);
                #1 cur_wen = 1'b0; cur_a = 32'h8000_0030; cur_be = 4'b0000;
                wen = 1'b0; addr = 32'h8000_0030;
                @(posedge CLK);
                @(posedge CLK);
                #1 addr = MISS;
                @(negedge CLK);
                @(negedge CLK);
                chk(sram_ce_n && sram_oe_n && !sram_wait, "abort_idle",
                    32'({sram_ce_n, sram_oe_n, sram_wait}), 32'h6);
                do_access(1'b1, 32'h8000_0034, 32'h7777_8888, 4'b1111);
                do_access(1'b0, 32'h8000_0034, 32'h0, 4'b0000);

                // asynchronous reset in the middle of an access
                @(posedge CLK);
                #1 cur_wen = 1'b0; cur_a = 32'h8000_0014; cur_be = 4'b0000;
                wen = 1'b0; addr = 32'h8000_0014;
                repeat (3) @(posedge CLK);
                #2 nRST = 1'b0;
                #1;
                chk(sram_ce_n && sram_oe_n && !sram_dq_oe, "async_rst_strobes",
                    32'({sram_ce_n, sram_oe_n, sram_dq_oe}), 32'h6);
                chk(sram_rdata == 32'h0, "async_rst_rdata", sram_rdata, 32'h0);
                model_rdata = '0;
                addr = MISS;
                @(posedge CLK);
                #1 nRST = 1'b1;

                for (int i = 0; i < 60; i++) begin
                    logic [31:0] ra;
                    ra = 32'h8000_0000 | (32'($urandom_range(0, 2047)) << 9)
                         | (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(0, 3));
                    do_access(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)));
                end

                repeat (3) @(negedge CLK);
                chk(sbq.size() == 0, "sb_empty", 32'(sbq.size()), 32'h0);
            end
            begin : mon
                forever begin
                    @(negedge CLK);
                    if (!sram_ce_n) begin
                        bit       ok;
                        bit       a0;
                        logic [1:0]  be2;
                        logic [15:0] dh;
                        a0 = sram_a[0];
                        ph = (prev_ce_low && prev_a0 == a0) ? ph + 1 : 0;
                        prev_ce_low = 1'b1;
                        prev_a0 = a0;
                        acc_ce++;
                        last_a = sram_a;
                        be2 = a0 ? cur_be[3:2] : cur_be[1:0];
                        dh  = a0 ? cur_d[31:16] : cur_d[15:0];
                        ok  = (sram_a[AB-2:1] == cur_a[AB-1:2]) && (ph <= W);
                        if (cur_wen)
                            ok = ok && sram_dq_oe && sram_oe_n && be2 != 2'b00
                                 && sram_lb_n == !be2[0] && sram_ub_n == !be2[1]
                                 && sram_dq_out == dh && sram_we_n == !(ph < W);
                        else
                            ok = ok && !sram_dq_oe && !sram_oe_n && sram_we_n
                                 && !sram_lb_n && !sram_ub_n;
                        chk(ok, "phase_strobes",
                            32'({sram_a[7:0], sram_dq_oe, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}),
                            32'({cur_a[8:2], a0, cur_wen, cur_wen, !(cur_wen && ph < W), !be2[0], !be2[1]}));
                    end else begin
                        prev_ce_low = 1'b0;
                        chk(sram_oe_n && sram_we_n && sram_lb_n && sram_ub_n && !sram_dq_oe, "idle_strobes",
                            32'({sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe}), 32'h1e);
                    end

                    if (!nRST || !sram_active) begin
                        cyc = 0;
                    end else if (sram_wait) begin
                        cyc++;
                    end else if (sbq.size() == 0) begin
                        chk(1'b0, "unexpected_done", sram_rdata, 32'h0);
                        cyc = 0;
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk(cyc == e.lat, "latency", 32'(cyc), 32'(e.lat));
                        chk(sram_rdata == e.exp_rd, "rdata", sram_rdata, e.exp_rd);
                        if (e.wr)
                            chk({dev[{e.word, 1'b1}], dev[{e.word, 1'b0}]} == e.exp_mem, "mem_word",
                                {dev[{e.word, 1'b1}], dev[{e.word, 1'b0}]}, e.exp_mem);
                        cyc = 0;
                    end
                end
            end
        join_any

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ext_sram_responder.md
# ext_sram_responder

Memory-block responder implementing the SRAM side of the SoC memory-blocks interface. Decodes the shared `addr`/`wen`/`wdata`/`byte_en` request, claims accesses in its address window, and converts each 32-bit word access into two 16-bit phases on an asynchronous external SRAM. It holds `sram_wait` high until the access finishes, then returns read data on `sram_rdata`. It sits beside the RAM and ROM responders, under the SoC memory mux.

## Interface
Parameters:
- `BASE_ADDR`, 32'h8000_0000: window base; the upper `32-ADDR_BITS` bits are compared.
- `ADDR_BITS`, 20: window size is 2^ADDR_BITS bytes; 2 ≤ ADDR_BITS ≤ 31.
- `WAIT_CYCLES`, 2: extra cycles per 16-bit phase; must be ≥ 1.

Ports:
- `CLK` in 1: clock.
- `nRST` in 1: asynchronous, active-low reset.
- `wen` in 1: 1 means write, 0 means read.
- `addr` in 32: byte address; bits [1:0] are ignored.
- `wdata` in 32: write data.
- `byte_en` in 4: byte lane enables; bit i covers `wdata[8i+7:8i]`.
- `sram_rdata` out 32: read data, registered.
- `sram_wait` out 1: access in progress, combinational.
- `sram_active` out 1: address hits this window, combinational.
- `sram_a` out ADDR_BITS-1: external halfword address.
- `sram_dq_out` out 16: external write data.
- `sram_dq_in` in 16: external read data.
- `sram_dq_oe` out 1: drive enable for the data pads.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_lb_n`, `sram_ub_n` out 1 each: active-low SRAM strobes.

## Operation
- `hit` = (`addr[31:ADDR_BITS]` == `BASE_ADDR[31:ADDR_BITS]`). `sram_active` = `hit`.
- `sram_wait` = `hit` && (state != DONE). When `hit`=0, `sram_wait`=0.
- FSM states: IDLE, LO, HI, DONE. A phase counter `pc` counts 0..WAIT_CYCLES.
- IDLE: if `hit`, latch `wen`, `wdata`, `byte_en`, and `addr[ADDR_BITS-1:2]`.
  - Read: go to LO.
  - Write with `byte_en[1:0]`≠0: go to LO.
  - Write with `byte_en[1:0]`=0 and `byte_en[3:2]`≠0: go to HI.
  - Write with `byte_en`=0: go to DONE; no external cycle occurs.
- LO / HI: each phase lasts WAIT_CYCLES+1 cycles, from `pc`=0 to `pc`=WAIT_CYCLES.
  - `sram_a` = {latched word address, 0 for LO or 1 for HI}.
  - `sram_ce_n`=0 for the whole phase.
- Read phase:
  - `sram_oe_n`=0, `sram_lb_n`=`sram_ub_n`=0, `sram_dq_oe`=0.
  - On the last cycle, capture `sram_dq_in` into `sram_rdata[15:0]` (LO) or `sram_rdata[31:16]` (HI).
- Write phase:
  - `sram_dq_oe`=1 and `sram_dq_out` = latched half of `wdata`.
  - `sram_lb_n`/`sram_ub_n` = inverted latched `byte_en` bits for that half.
  - `sram_we_n`=0 for `pc` < WAIT_CYCLES, and 1 on the last cycle (data hold).
- Phase exit:
  - LO to HI, except a write with `byte_en[3:2]`=0 goes from LO to DONE.
  - HI to DONE.
- DONE: lasts one cycle, with all strobes inactive and `sram_wait`=0 so the master can advance. The next state is IDLE.
- Any `hit` still present in IDLE starts a new access. A repeated read or write of the same word is harmless.
- Abort: if `hit` drops in LO or HI (a protocol violation), the next state is IDLE. Strobes go inactive and `sram_rdata` keeps its partial contents.
- Bytes not enabled are never written. Reads always fetch both halves.

## Timing
- Reset values:
  - State IDLE, `pc`=0.
  - `sram_rdata`=0.
  - `sram_ce_n`=`sram_oe_n`=`sram_we_n`=`sram_lb_n`=`sram_ub_n`=1.
  - `sram_dq_oe`=0, `sram_dq_out`=0, `sram_a`=0.
- All SRAM-side outputs are registered, so they are glitch-free. Asserting `nRST` mid-access forces every strobe inactive immediately, without waiting for a clock edge.
- Full-word access latency, counted from the cycle `hit` first appears (cycle 0):
  - LO runs cycles 1..W+1; HI runs cycles W+2..2W+2; DONE is cycle 2W+3.
  - With W=2: `sram_wait`=1 for cycles 0..6, and `sram_rdata` is valid with `sram_wait`=0 in cycle 7.
- Single-half write: DONE at cycle W+2.
- Write with `byte_en`=0: DONE at cycle 1.
- `sram_rdata` changes only on phase-capture edges, so it holds its value through DONE and IDLE.

## Test plan
- Reset: hold `nRST`=0 while the bench drives `hit`. Required: all strobes are 1, `sram_dq_oe`=0, `sram_rdata`=0, `sram_wait`=1 (combinational).
- Read 0x8000_0010, SRAM model returns halfword 8=0xBEEF and halfword 9=0xDEAD, W=2:
  - `sram_wait` is high for 7 cycles.
  - Cycle 7: `sram_rdata`=0xDEADBEEF, `sram_wait`=0.
- Write 0x8000_0020, `wdata`=0x1122_3344, `byte_en`=4'b0110:
  - LO phase: `sram_lb_n`=1, `sram_ub_n`=0.
  - HI phase: `sram_lb_n`=0, `sram_ub_n`=1.
  - Model memory holds 0x??22_33?? with the untouched bytes preserved.
- Write with `byte_en`=4'b1100: only the HI phase occurs, with `sram_a`=0x11; DONE comes at cycle 4.
- Write with `byte_en`=0: no `sram_ce_n` pulse; `sram_wait`=0 at cycle 1.
- Miss 0x4000_0000: `sram_active`=0, `sram_wait`=0, no strobes.
- Abort: drop `hit` during LO. Required: IDLE next cycle, strobes inactive, no DONE cycle.
